serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving the idle cycles between repeats (0 allowed).
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  frame request, accepted only when ready=1.
REQ-006 The block SHALL have port pattern  input  WIDTH  bits to send; active field is pattern[len-1:0].
REQ-007 The block SHALL have port len  input  4  active bit count, with valid values 1..WIDTH.
REQ-008 The block SHALL have port repeat_cnt  input  4  extra repetitions; 0 means send once.
REQ-009 The block SHALL have port abort  input  1  synchronous frame cancel.
REQ-010 The block SHALL have port ready  output  1  high when idle and able to accept start.
REQ-011 The block SHALL have port out  output  1  serial bit, MSB of the active field first; feeds the sequence-detector serial input.
REQ-012 The block SHALL have port out_valid  output  1  high on every cycle that out carries a pattern bit.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse after the final bit of a non-aborted frame.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SHIFT, GAP, DONE.
REQ-015 In IDLE, start=1 with abort=0 SHALL capture pattern, len and repeat_cnt, and SHALL move to SHIFT on the next edge.
REQ-016 Captured values SHALL be held for the whole frame; input changes after acceptance SHALL be ignored.
REQ-017 A len of 0, or a len greater than WIDTH, SHALL be treated as WIDTH.
REQ-018 The first bit SHALL appear on out, with out_valid=1, in the cycle after start is sampled (latency 1).
REQ-019 SHIFT SHALL present one bit per cycle, from pattern[len-1] down to pattern[0].
REQ-020 After bit 0, if repeats remain and GAP_CYCLES>0, the FSM SHALL go to GAP; if GAP_CYCLES=0 it SHALL restart SHIFT directly with no bubble.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, with out=0 and out_valid=0, and SHALL then return to SHIFT from pattern[len-1].
REQ-022 The repeat counter SHALL decrement at each restart; the frame SHALL total len*(repeat_cnt+1) valid bits and GAP_CYCLES*repeat_cnt gap cycles.
REQ-023 After the last bit of the last repetition, the FSM SHALL enter DONE for one cycle with done=1, out=0 and out_valid=0, then return to IDLE.
REQ-024 ready SHALL be 1 only in IDLE, so it is 0 in SHIFT, GAP and DONE; start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 abort=1 in SHIFT, GAP or DONE SHALL force IDLE on the next edge, with out=0, out_valid=0 and no done pulse.
REQ-026 abort=1 and start=1 in the same cycle in IDLE SHALL leave the FSM in IDLE, because abort wins.
REQ-027 out SHALL be 0 whenever out_valid=0.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 nReset=0 SHALL immediately and asynchronously force: state IDLE, out=0, out_valid=0, done=0, ready=1, with all counters and captured registers cleared.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no done pulse; the first start accepted after release SHALL begin a fresh frame.
REQ-031 Deassertion of nReset SHALL take effect at the next rising edge; the block SHALL accept start no earlier than that edge.

Verification
REQ-032 Scenario: pattern=8'h0B, len=4, repeat_cnt=0, start for 1 cycle -> out=1,0,1,1 with out_valid=1 on cycles 1-4, done=1 on cycle 5, ready=1 on cycle 6.
REQ-033 Scenario: pattern=8'h07, len=3, repeat_cnt=2, GAP_CYCLES=1 -> out_valid pattern 111 0 111 0 111 (11 cycles), then done.
REQ-034 Scenario: len=0, pattern=8'hA5 -> 8 valid bits 1,0,1,0,0,1,0,1, then done.
REQ-035 Scenario: start pulsed during SHIFT, then abort at bit 2 of an 8-bit frame -> second start ignored; out_valid=0 and ready=1 on the next cycle; done never asserted.
REQ-036 Scenario: start=1 and abort=1 together in IDLE -> remains IDLE; out_valid stays 0 and ready stays 1.
REQ-037 Scenario: nReset pulsed low for 3 ns mid-frame, between clock edges -> outputs reach their reset values without waiting for a clock edge; the next start produces a full, correct frame.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a captured pattern out MSB-first, repeating with
// optional idle gaps, and pulses done at the end of an uninterrupted frame.
module serial_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    input  logic [3:0]       repeat_cnt,
    input  logic             abort,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [IW-1:0]    r_top;
    logic [IW-1:0]    r_idx;
    logic [3:0]       r_rep;
    logic [GW-1:0]    r_gap;

    logic [IW-1:0]    w_top;
    logic [IW-1:0]    w_idx_dec;

    // Index of the first bit to send; out-of-range lengths mean the full width
    assign w_top     = (len == 4'd0 || 32'(len) > WIDTH) ? IW'(WIDTH - 1)
                                                          : IW'(len - 4'd1);
    assign w_idx_dec = r_idx - IW'(1);

    // Frame FSM; outputs are registered and reflect the state being entered
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_top     <= '0;
            r_idx     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_pat     <= pattern;
                        r_top     <= w_top;
                        r_idx     <= w_top;
                        r_rep     <= repeat_cnt;
                        out       <= pattern[w_top];
                        out_valid <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state <= IDLE;
                        ready   <= 1'b1;
                    end else if (r_idx != '0) begin
                        r_idx     <= w_idx_dec;
                        out       <= r_pat[w_idx_dec];
                        out_valid <= 1'b1;
                    end else if (r_rep != 4'd0) begin
                        r_rep <= r_rep - 4'd1;
                        if (GAP_CYCLES > 0) begin
                            r_gap   <= GW'(GAP_CYCLES - 1);
                            r_state <= GAP;
                        end else begin
                            r_idx     <= r_top;
                            out       <= r_pat[r_top];
                            out_valid <= 1'b1;
                        end
                    end else begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                GAP: begin
                    if (abort) begin
                        r_state <= IDLE;
                        ready   <= 1'b1;
                    end else if (r_gap == '0) begin
                        r_idx     <= r_top;
                        out       <= r_pat[r_top];
                        out_valid <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: the driver pushes the expected
// per-cycle output trace of each frame, the monitor checks every cycle.
module tb_serial_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned GAP   = 1;

    logic             clk = 1'b0;
    logic             nReset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [3:0]       len = '0;
    logic [3:0]       repeat_cnt = '0;
    logic             abort = 1'b0;
    logic             ready, out, out_valid, done;

    serial_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .nReset(nReset), .start(start), .pattern(pattern),
        .len(len), .repeat_cnt(repeat_cnt), .abort(abort), .ready(ready),
        .out(out), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    // entry = {out_valid, out, done, ready}
    logic [3:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got {valid,out,done,ready}=%b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare against the queued trace, otherwise expect idle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0)
                check("frame_cycle", {out_valid, out, done, ready}, exp_q.pop_front());
            else
                check("idle", {out_valid, out, done, ready}, 4'b0001);
        end
    end

    // Reference: the whole frame as a list of cycles after start is sampled
    task automatic build_trace(input logic [WIDTH-1:0] pat, input int l_in, input int rep,
                               output logic [3:0] tr[$]);
        int l;
        l = (l_in == 0 || l_in > int'(WIDTH)) ? int'(WIDTH) : l_in;
        tr.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = l - 1; b >= 0; b--) tr.push_back({1'b1, pat[b], 2'b00});
            if (r < rep) for (int g = 0; g < int'(GAP); g++) tr.push_back(4'b0000);
        end
        tr.push_back(4'b0010);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 4'(exp_q.size()), 4'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Issue a frame; abort_at>0 asserts abort in that cycle (1 = first bit),
    // spur pulses start in the first bit cycle, rst_at>0 pulses reset there.
    task automatic send_frame(input logic [WIDTH-1:0] pat, input logic [3:0] l,
                              input logic [3:0] rep, input int abort_at,
                              input bit spur, input int rst_at);
        logic [3:0] tr[$];
        int c;
        pattern = pat; len = l; repeat_cnt = rep; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pattern = WIDTH'($urandom); len = 4'($urandom); repeat_cnt = 4'($urandom);
        build_trace(pat, int'(l), int'(rep), tr);
        if (abort_at > 0) while (tr.size() > abort_at) void'(tr.pop_back());
        foreach (tr[i]) exp_q.push_back(tr[i]);
        c = 1;
        start = spur;
        while (1) begin
            if (rst_at > 0 && c == rst_at) begin
                start = 1'b0;
                nReset = 1'b0;
                exp_q.delete();
                #1;
                check("async_reset", {out_valid, out, done, ready}, 4'b0001);
                #2;
                nReset = 1'b1;
                @(posedge clk); #1;
                break;
            end
            abort = (abort_at > 0 && c == abort_at);
            if (!(spur && c == 1) && abort_at == 0 && rst_at == 0) break;
            if (abort_at > 0 && c > abort_at) begin abort = 1'b0; break; end
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end
        abort = 1'b0;
        wait_drain();
    endtask

    initial begin
        #1 nReset = 1'b0;
        #12;
        check("reset_state", {out_valid, out, done, ready}, 4'b0001);
        nReset = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h0B, 4'd4, 4'd0, 0, 1'b0, 0);
        send_frame(8'h07, 4'd3, 4'd2, 0, 1'b0, 0);
        send_frame(8'hA5, 4'd0, 4'd0, 0, 1'b0, 0);
        send_frame(8'h3C, 4'd8, 4'd0, 3, 1'b1, 0);
        send_frame(8'hFF, 4'd1, 4'd0, 0, 1'b0, 0);
        send_frame(8'h96, 4'd12, 4'd1, 0, 1'b0, 0);
        // start together with abort in idle: nothing happens
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'hC3, 4'd8, 4'd1, 0, 1'b0, 5);
        send_frame(8'h5A, 4'd8, 4'd0, 0, 1'b0, 0);
        for (int k = 0; k < 40; k++) begin
            logic [3:0] l, r;
            int ab, li;
            l = 4'($urandom);
            r = 4'($urandom_range(0, 3));
            li = (l == 0 || l > 4'(WIDTH)) ? int'(WIDTH) : int'(l);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, li * (int'(r) + 1) + int'(r))) : 0;
            send_frame(WIDTH'($urandom), l, r, ab, 1'($urandom), 0);
        end
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
